// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter and the register
// file. One header so both sides agree on widths and the hard-wired zero register.
package rf_wb_arbiter_pkg;

  localparam int unsigned INST_REG_ADDR = 5;
  localparam int unsigned INST_REG_DATA = 32;
  localparam int unsigned REG_NUM       = 32;

  localparam logic [INST_REG_ADDR-1:0] ZERO_REG_ADDR = '0;
  localparam logic [INST_REG_DATA-1:0] ZERO_WORD     = '0;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_result_fifo: small synchronous FIFO that holds multi-cycle results waiting
// for the register-file write port. It tracks its occupancy and has an async
// active-low reset. DEPTH must be a power of two, so the pointers wrap naturally.
module wb_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written on push only.
  // NOTE: the data array has no reset; the count and pointers alone decide
  // which entries are valid, so clearing storage would add cost with no effect.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy. Push and pop together leave the count unchanged.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback
// (priority) and buffered multi-cycle results. It keeps a pending-destination
// scoreboard that drives the decode hazard stall.
// Optional build macro RF_ARB_STARVE_EN: starvation relief. After STARVE_LIMIT
// blocked cycles it raises wb_stall, so the buffer gets one write slot.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = INST_REG_DATA,
  parameter int unsigned ADDR_W       = INST_REG_ADDR,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr_en,
  input  logic [ADDR_W-1:0] pipe_wr_addr,
  input  logic [DATA_W-1:0] pipe_wr_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  input  logic [ADDR_W-1:0] id_rd_addr,
  output logic              hazard_stall,
  output logic              wb_stall,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG_ADDR);

  logic               push, pop;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_fifo_full;
  logic               fifo_empty;
  logic [REG_NUM-1:0] pending_q, pending_d;

  assign {head_addr, head_data} = head;

  // Readiness comes from the registered count only: no pass-through when full.
  assign mc_ready = (fifo_count < CNT_W'(BUF_DEPTH));
  assign push     = mc_valid && mc_ready;
  // The buffer gets the port only in cycles without a pipeline write.
  assign pop      = !pipe_wr_en && !fifo_empty;

  wb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({mc_addr, mc_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  // Write-port mux: pipeline first, then buffer head. An x0 head drains silently.
  // NOTE: each output gets a default first, so no path through the block can
  // leave a value held, and no latch is inferred.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = R0;
    rf_wr_data = DATA_W'(ZERO_WORD);
    if (pipe_wr_en) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = pipe_wr_addr;
      rf_wr_data = pipe_wr_data;
    end else if (!fifo_empty && (head_addr != R0)) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = head_addr;
      rf_wr_data = head_data;
    end
  end

  // Scoreboard next state: a buffer write clears its bit, an issue sets it; set wins.
  always_comb begin
    pending_d = pending_q;
    if (pop && (head_addr != R0)) pending_d[head_addr] = 1'b0;
    if (issue_en && (issue_addr != R0)) pending_d[issue_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hazard_stall = ((id_rs1_addr != R0) && pending_q[id_rs1_addr]) ||
                        ((id_rs2_addr != R0) && pending_q[id_rs2_addr]) ||
                        ((id_rd_addr  != R0) && pending_q[id_rd_addr]);

  assign busy = !fifo_empty || (|pending_q);

`ifdef RF_ARB_STARVE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                wb_stall_q, wb_stall_d;

  // Count cycles in which the buffer waits behind the pipeline. Any buffer write clears the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wb_stall_d   = wb_stall_q;
    if (pop) begin
      starve_cnt_d = '0;
      wb_stall_d   = 1'b0;
    end else if (pipe_wr_en && !fifo_empty) begin
      if (starve_cnt_q < STARVE_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      if (starve_cnt_d >= STARVE_W'(STARVE_LIMIT)) wb_stall_d = 1'b1;
    end
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      wb_stall_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_stall_q   <= wb_stall_d;
    end
  end

  assign wb_stall = wb_stall_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. Directed scenarios, then random
// traffic, all compared cycle by cycle against a queue-based reference model.
// Honours RF_ARB_STARVE_EN the same way the design does.
module tb_rf_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_wr_en;
  logic [ADDR_W-1:0] pipe_wr_addr;
  logic [DATA_W-1:0] pipe_wr_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic              hazard_stall, wb_stall, rf_wr_en, busy;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  rf_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .hazard_stall(hazard_stall), .wb_stall(wb_stall),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the buffered results in arrival order, the set of
  // outstanding destinations, and the starvation state.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } res_t;

  res_t mq[$];
  bit   pend[32];
  bit   m_stall = 1'b0;
  int   m_blocked = 0;

  function automatic bit m_pending(input logic [ADDR_W-1:0] a);
    return (a != 0) && pend[a];
  endfunction

  function automatic bit m_any_pending();
    for (int i = 0; i < 32; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_stall   = 1'b0;
    m_blocked = 0;
  endtask

  task automatic idle();
    pipe_wr_en = 0; pipe_wr_addr = '0; pipe_wr_data = '0;
    mc_valid = 0; mc_addr = '0; mc_data = '0;
    issue_en = 0; issue_addr = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
  endtask

  task automatic check_outputs();
    check("mc_ready", mc_ready, mq.size() < BUF_DEPTH);
    check("wb_stall", wb_stall, m_stall);
    check("hazard_stall", hazard_stall,
          m_pending(id_rs1_addr) || m_pending(id_rs2_addr) || m_pending(id_rd_addr));
    check("busy", busy, (mq.size() != 0) || m_any_pending());
    if (pipe_wr_en) begin
      check("wr_en_pipe", rf_wr_en, 1);
      check("wr_addr_pipe", rf_wr_addr, pipe_wr_addr);
      check("wr_data_pipe", rf_wr_data, pipe_wr_data);
    end else if (mq.size() != 0) begin
      check("wr_en_buf", rf_wr_en, mq[0].addr != 0);
      if (mq[0].addr != 0) begin
        check("wr_addr_buf", rf_wr_addr, mq[0].addr);
        check("wr_data_buf", rf_wr_data, mq[0].data);
      end
    end else begin
      check("wr_en_idle", rf_wr_en, 0);
      check("wr_addr_idle", rf_wr_addr, 0);
      check("wr_data_idle", rf_wr_data, 0);
    end
  endtask

  // Applies what happens at a clock edge, using the inputs held during that cycle.
  task automatic model_edge();
    int   size_before = mq.size();
    bit   popped = !pipe_wr_en && (size_before != 0);
    bit   pushed = mc_valid && (size_before < BUF_DEPTH);
    res_t e;
    if (popped) begin
      e = mq.pop_front();
      if (e.addr != 0) pend[e.addr] = 1'b0;
    end
    if (issue_en && issue_addr != 0) pend[issue_addr] = 1'b1;
    if (pushed) begin
      e.addr = mc_addr;
      e.data = mc_data;
      mq.push_back(e);
    end
`ifdef RF_ARB_STARVE_EN
    if (popped) begin
      m_blocked = 0;
      m_stall   = 1'b0;
    end else if (pipe_wr_en && size_before != 0) begin
      m_blocked++;
      if (m_blocked >= STARVE_LIMIT) m_stall = 1'b1;
    end
`endif
  endtask

  // One cycle: called at a falling edge with the inputs already set.
  task automatic step();
    if (m_stall) pipe_wr_en = 0;  // the pipeline keeps its side of the starvation handshake
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Reset asserted between edges, then released at the next falling edge.
  task automatic mid_reset(input logic [ADDR_W-1:0] probe);
    #2;
    rst_n = 0;
    id_rs1_addr = probe;
    #1;
    model_reset();
    check("rst_mc_ready", mc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wb_stall", wb_stall, 0);
    check("rst_hazard", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;
    @(negedge clk);

    // Op issued to x5; its result arrives while the pipeline is idle.
    issue_en = 1; issue_addr = 5; id_rs1_addr = 5; step();
    idle(); id_rs1_addr = 5; mc_valid = 1; mc_addr = 5; mc_data = 32'h1234; step();
    idle(); id_rs1_addr = 5; step();   // x5 written from the buffer
    idle(); id_rs1_addr = 5; step();   // stall has dropped

    // Pipeline write to x3 collides with a buffered x7 result.
    idle(); issue_en = 1; issue_addr = 7; mc_valid = 1; mc_addr = 7; mc_data = 32'h77; step();
    idle(); pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'hA; id_rd_addr = 7; step();
    idle(); id_rd_addr = 7; step();
    idle(); id_rd_addr = 7; step();

    // Three results back to back while the pipeline holds the port.
    for (int i = 0; i < 3; i++) begin
      idle();
      pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 32'h100 + i;
      mc_valid = 1; mc_addr = ADDR_W'(10 + i); mc_data = 32'hB00 + i;
      step();
    end
    idle(); mc_valid = 1; mc_addr = 12; mc_data = 32'hB02; step();  // third still held
    idle(); mc_valid = 1; mc_addr = 12; mc_data = 32'hB02; step();  // accepted alongside a pop
    idle(); repeat (3) step();

    // x9 reissued in the cycle its previous result is written: stays pending.
    idle(); issue_en = 1; issue_addr = 9; step();
    idle(); mc_valid = 1; mc_addr = 9; mc_data = 32'h99; id_rs2_addr = 9; step();
    idle(); issue_en = 1; issue_addr = 9; id_rs2_addr = 9; step();
    idle(); id_rs2_addr = 9; step();
    idle(); mc_valid = 1; mc_addr = 9; mc_data = 32'h999; id_rs2_addr = 9; step();
    idle(); id_rs2_addr = 9; step();
    idle(); id_rs2_addr = 9; step();

    // A result for x0 drains without a write.
    idle(); mc_valid = 1; mc_addr = 0; mc_data = 32'hDEAD; step();
    idle(); step();

`ifdef RF_ARB_STARVE_EN
    // Pipeline holds the port with a result buffered: relief after the limit.
    idle(); mc_valid = 1; mc_addr = 2; mc_data = 32'h22; step();
    n = 0;
    while (n < 10 && !wb_stall) begin
      idle(); pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 32'h5;
      step();
      n++;
    end
    check("starve_cycles", n, STARVE_LIMIT);
    idle(); pipe_wr_en = 1; pipe_wr_addr = 1; step();  // forced idle, head written
    idle(); step();
`endif

    // Reset with two buffered results and x4 pending.
    idle(); issue_en = 1; issue_addr = 4; step();
    idle(); pipe_wr_en = 1; pipe_wr_addr = 1; mc_valid = 1; mc_addr = 20; mc_data = 32'h20; step();
    idle(); pipe_wr_en = 1; pipe_wr_addr = 1; mc_valid = 1; mc_addr = 21; mc_data = 32'h21; step();
    idle(); pipe_wr_en = 1; pipe_wr_addr = 1; id_rs1_addr = 4; #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_hazard", hazard_stall, 1);
    check("pre_rst_ready", mc_ready, 0);
    mid_reset(4);
    step();

    // Random traffic over a small register range so hazards recur.
    for (int i = 0; i < 400; i++) begin
      idle();
      pipe_wr_en   = ($urandom_range(0, 99) < 50);
      pipe_wr_addr = ADDR_W'($urandom_range(0, 7));
      pipe_wr_data = $urandom;
      mc_valid     = ($urandom_range(0, 99) < 50);
      mc_addr      = ADDR_W'($urandom_range(0, 7));
      mc_data      = $urandom;
      issue_en     = ($urandom_range(0, 99) < 30);
      issue_addr   = ADDR_W'($urandom_range(0, 7));
      id_rs1_addr  = ADDR_W'($urandom_range(0, 7));
      id_rs2_addr  = ADDR_W'($urandom_range(0, 7));
      id_rd_addr   = ADDR_W'($urandom_range(0, 7));
      if (i == 200) mid_reset(ADDR_W'($urandom_range(0, 7)));
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
